// File: rtl/sm1_sched_pkg.sv
// rtl/sm1_sched_pkg.sv - shared types and defaults for the SM1 frame scheduler
// Purpose: scheduler FSM state encoding and default sizing.
// Ports: none (package).
package sm1_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    REPORT
  } sched_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_FRAME_W = 8;

endpackage

// File: rtl/sm1_frame_scheduler_rr_arbiter.sv
// rtl/sm1_frame_scheduler_rr_arbiter.sv - combinational round-robin picker
// Purpose: grants the first set request after ptr, wrapping modulo N_REQ.
// Ports:
//   req    in   N_REQ   request levels
//   ptr    in   IDX_W   index of the last served requester (lowest priority)
//   grant  out  N_REQ   one-hot winner, zero when no request
//   any    out  1       at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // Scan ptr+1, ptr+2, ... so the previous owner is considered last.
    for (int off = 1; off <= N_REQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sm1_frame_scheduler.sv
// rtl/sm1_frame_scheduler.sv - time-shares one SM1 detector among requesters
// Purpose: round-robin picks a requester, clears SM1, shifts its frame in
// MSB-first, counts SM1 output pulses and reports the count with a done pulse.
// Ports:
//   clock       in   1              rising-edge clock
//   reset       in   1              synchronous, active-low
//   req         in   N_REQ          level request per requester
//   frame_data  in   N_REQ*FRAME_W  frame of requester i at [i*FRAME_W +: FRAME_W]
//   gnt         out  N_REQ          one-hot 1-cycle pulse, frame latched
//   done        out  N_REQ          one-hot 1-cycle pulse, hits valid
//   hits        out  CNT_W          pulse count of last frame, held until next done
//   busy        out  1              high outside IDLE
//   sm_reset    out  1              SM1 reset, active-high
//   sm_entrada  out  1              SM1 serial input
//   sm_saida    in   1              SM1 output (registered in SM1)
module sm1_frame_scheduler
  import sm1_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_W-1:0]   frame_data,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [CNT_W-1:0]           hits,
  output logic                       busy,
  output logic                       sm_reset,
  output logic                       sm_entrada,
  input  logic                       sm_saida
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  sched_state_t       state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]   owner, owner_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   bit_cnt, bit_d;
  logic [CNT_W-1:0]   hit_cnt, hit_d;
  logic [CNT_W-1:0]   hit_inc;
  logic [N_REQ-1:0]   gnt_d, done_d;
  logic [CNT_W-1:0]   hits_d;
  logic               busy_d, sm_reset_d, sm_entrada_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_any;
  logic [IDX_W-1:0]   win_idx;
  logic [FRAME_W-1:0] win_frame;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_gnt),
    .any   (arb_any)
  );

  always_comb begin
    win_idx   = '0;
    win_frame = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_idx   = IDX_W'(i);
        win_frame = frame_data[i*FRAME_W +: FRAME_W];
      end
    end
  end

  // SM1 output lags its input by one cycle, so the sample taken in a given
  // cycle belongs to the bit driven in the previous cycle.
  assign hit_inc = hit_cnt + CNT_W'(sm_saida);

  // Outputs are registered: everything below is the value for the next cycle.
  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    owner_d      = owner;
    frame_d      = frame_q;
    bit_d        = bit_cnt;
    hit_d        = hit_cnt;
    gnt_d        = '0;
    done_d       = '0;
    hits_d       = hits;
    sm_reset_d   = 1'b1;
    sm_entrada_d = 1'b0;

    case (state)
      IDLE: begin
        if (arb_any) begin
          owner_d = win_idx;
          frame_d = win_frame;
          gnt_d   = arb_gnt;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        hit_d        = '0;
        bit_d        = '0;
        sm_reset_d   = 1'b0;
        sm_entrada_d = frame_q[FRAME_W-1];
        frame_d      = frame_q << 1;
        state_d      = SHIFT;
      end
      SHIFT: begin
        // The first SHIFT cycle still sees the cleared SM1 output.
        if (bit_cnt != '0) begin
          hit_d = hit_inc;
        end
        sm_reset_d = 1'b0;
        if (bit_cnt == LAST_BIT) begin
          state_d = DRAIN;
        end else begin
          bit_d        = bit_cnt + CNT_W'(1);
          sm_entrada_d = frame_q[FRAME_W-1];
          frame_d      = frame_q << 1;
        end
      end
      DRAIN: begin
        // Picks up the response to the last frame bit.
        hit_d    = hit_inc;
        hits_d   = hit_inc;
        done_d   = N_REQ'(1) << owner;
        rr_ptr_d = owner;
        state_d  = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= IDX_W'(N_REQ - 1);
      owner      <= '0;
      frame_q    <= '0;
      bit_cnt    <= '0;
      hit_cnt    <= '0;
      gnt        <= '0;
      done       <= '0;
      hits       <= '0;
      busy       <= 1'b0;
      sm_reset   <= 1'b1;
      sm_entrada <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      owner      <= owner_d;
      frame_q    <= frame_d;
      bit_cnt    <= bit_d;
      hit_cnt    <= hit_d;
      gnt        <= gnt_d;
      done       <= done_d;
      hits       <= hits_d;
      busy       <= busy_d;
      sm_reset   <= sm_reset_d;
      sm_entrada <= sm_entrada_d;
    end
  end

endmodule
